// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch/decode handshake and head-entry bus for the fetch queue
interface fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  logic                   ValidF;
  logic [XLEN-1:0]        RDF;
  logic [XLEN-1:0]        PCF;
  logic [XLEN-1:0]        PCPlus4F;
  logic                   StallD;
  logic                   FlushD;
  logic                   StallF;
  logic                   ValidD;
  logic [XLEN-1:0]        InstrD;
  logic [XLEN-1:0]        PCD;
  logic [XLEN-1:0]        PCPlus4D;
  logic [$clog2(DEPTH):0] CountQ;
  modport master (
    output ValidF, RDF, PCF, PCPlus4F, StallD, FlushD,
    input  StallF, ValidD, InstrD, PCD, PCPlus4D, CountQ
  );
  modport slave (
    input  ValidF, RDF, PCF, PCPlus4F, StallD, FlushD,
    output StallF, ValidD, InstrD, PCD, PCPlus4D, CountQ
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order fetch-to-decode instruction buffer with flush; FETCHQ_BYPASS_EN enables same-cycle bypass through an empty queue
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);
  logic [XLEN-1:0] instrMem [DEPTH];
  logic [XLEN-1:0] pcMem [DEPTH];
  logic [XLEN-1:0] pcPlus4Mem [DEPTH];
  logic [AW-1:0]   headPtr, tailPtr;
  logic [AW:0]     count;
  logic            empty, full, bypass, push, pop;
  // status from registered count, head read (or bypassed fetch word), and push/pop qualification
  always_comb begin
    empty = count == '0;
    full = count == FullCount;
`ifdef FETCHQ_BYPASS_EN
    bypass = empty & bus.ValidF & ~bus.FlushD;
`else
    bypass = 1'b0;
`endif
    bus.StallF = full;
    bus.ValidD = ~empty | bypass;
    bus.CountQ = count;
    bus.InstrD = bypass ? bus.RDF : empty ? '0 : instrMem[headPtr];
    bus.PCD = bypass ? bus.PCF : empty ? '0 : pcMem[headPtr];
    bus.PCPlus4D = bypass ? bus.PCPlus4F : empty ? '0 : pcPlus4Mem[headPtr];
    pop = ~empty & ~bus.StallD & ~bus.FlushD;
    push = bus.ValidF & ~full & ~bus.FlushD & ~(bypass & ~bus.StallD);
  end
  // entry storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[tailPtr] <= bus.RDF;
      pcMem[tailPtr] <= bus.PCF;
      pcPlus4Mem[tailPtr] <= bus.PCPlus4F;
    end
  end
  // pointers and occupancy; reset and flush both empty the queue outright
  always_ff @(posedge clk) begin
    if (rst || bus.FlushD) begin
      headPtr <= '0;
      tailPtr <= '0;
      count <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + 1'b1;
      if (pop) headPtr <= headPtr + 1'b1;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a queue-based reference model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [31:0] i;
    logic [31:0] p;
    logic [31:0] p4;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic acc;
  ent_t q[$];
  fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus();
  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [31:0] pc, input logic sd, input logic fl, input logic r);
    ent_t e, h;
    logic byp, pushing, popping;
    e.i = r ? 32'hDEADBEEF : pc ^ 32'hC0DE0000;
    e.p = pc;
    e.p4 = pc + 32'd4;
    rst = r;
    bus.ValidF = v;
    bus.RDF = e.i;
    bus.PCF = e.p;
    bus.PCPlus4F = e.p4;
    bus.StallD = sd;
    bus.FlushD = fl;
    @(negedge clk);
    byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    byp = q.size() == 0 && v && !fl;
`endif
    h = byp ? e : q.size() > 0 ? q[0] : '0;
    if (!r) begin
      chk("ValidD", 32'(bus.ValidD), 32'(byp || q.size() > 0));
      chk("StallF", 32'(bus.StallF), 32'(q.size() == DEPTH));
      chk("CountQ", 32'(bus.CountQ), 32'(q.size()));
      chk("InstrD", bus.InstrD, h.i);
      chk("PCD", bus.PCD, h.p);
      chk("PCPlus4D", bus.PCPlus4D, h.p4);
    end
    acc = 1'b0;
    if (r || fl) q.delete();
    else begin
      pushing = v && q.size() < DEPTH;
      popping = q.size() > 0 && !sd;
      if (byp && !sd) begin
        pushing = 1'b0;
        acc = 1'b1;
      end
      if (popping) void'(q.pop_front());
      if (pushing) begin
        q.push_back(e);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] fpc;
    logic v, sd, fl, r;
    cyc(1, 32'h0, 0, 0, 1);
    cyc(1, 32'h0, 0, 0, 1);
    chk("rstCount", 32'(bus.CountQ), 32'd0);
    cyc(0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 32'h1000 + 32'(4 * k), 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 32'h2000 + 32'(4 * k), 1, 0, 0);
    chk("fillCount", 32'(bus.CountQ), 32'd4);
    cyc(1, 32'h2010, 0, 0, 0);
    chk("fullPopCount", 32'(bus.CountQ), 32'd3);
    cyc(1, 32'h2010, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 32'h0, 0, 0, 0);
    for (int rd = 0; rd < 4; rd++) begin
      for (int k = 0; k < 3; k++) cyc(1, 32'h5000 + 32'(16 * rd + 4 * k), 1, 0, 0);
      for (int k = 0; k < 3; k++) cyc(0, 32'h0, 0, 0, 0);
    end
    chk("wrapCount", 32'(bus.CountQ), 32'd0);
    for (int k = 0; k < 3; k++) cyc(1, 32'h2F00 + 32'(4 * k), 1, 0, 0);
    cyc(1, 32'h3000, 1, 1, 0);
    chk("flushCount", 32'(bus.CountQ), 32'd0);
    cyc(1, 32'h3004, 1, 0, 0);
    cyc(0, 32'h0, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0);
    fpc = 32'h4000;
    for (int n = 0; n < 400; n++) begin
      v = $urandom_range(0, 3) != 0;
      sd = $urandom_range(0, 2) == 0;
      fl = $urandom_range(0, 15) == 0;
      r = $urandom_range(0, 49) == 0;
      cyc(v, fpc, sd, fl, r);
      if (acc) fpc = fpc + 32'd4;
      if (fl || r) fpc = 32'h4000 + 32'($urandom_range(0, 255)) * 32'd16;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and the decode stage of the combined ARM/RISC-V pipeline. Each cycle it accepts one fetched word with its PC and PC+4, and holds up to DEPTH entries in order. It presents the oldest entry to decode and drives StallF back to fetch when full. A decode-side flush (taken branch or PC redirect) discards all buffered wrong-path instructions.

## Interface
- DEPTH, 4: number of entries; power of two, ≥ 2.
- XLEN, 32: width of instruction and address fields.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ValidF  in  1  fetch presents a valid word this cycle.
- RDF  in  XLEN  fetched instruction word.
- PCF  in  XLEN  address of RDF.
- PCPlus4F  in  XLEN  PCF + 4, computed by fetch.
- StallD  in  1  decode cannot accept the head entry this cycle.
- FlushD  in  1  discard all entries and any push this cycle.
- StallF  out  1  queue full; fetch must hold PCF.
- ValidD  out  1  head entry valid.
- InstrD  out  XLEN  head instruction.
- PCD  out  XLEN  head PC.
- PCPlus4D  out  XLEN  head PC+4.
- CountQ  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: circular buffer of DEPTH entries {instr, pc, pcplus4}, with head pointer, tail pointer and occupancy counter. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no special case.
- push = ValidF & ~StallF & ~FlushD. Writes the entry at tail, then tail+1.
- pop = ValidD & ~StallD & ~FlushD. Advances head by 1.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full (count == DEPTH):
  - StallF = 1.
  - Push is refused even if a pop occurs the same cycle.
  - Fetch re-presents the same word next cycle.
- Empty (count == 0): ValidD = 0. Pop is impossible.
- Outputs when ValidD = 0: InstrD, PCD and PCPlus4D are all-zero. They never show stale data.
- FlushD = 1:
  - Next cycle: head = tail = 0 and count = 0.
  - The same-cycle ValidF word is dropped.
  - FlushD has priority over push and pop.
- rst: same effect as FlushD, and has priority over everything. Reset asserted mid-operation empties the queue on the next edge with no partial state.
- No arithmetic on data fields; PCPlus4F is stored as given.

## Timing
- Reset values, in the cycle after rst:
  - StallF = 0, ValidD = 0, CountQ = 0.
  - InstrD = PCD = PCPlus4D = 0.
- Push-to-output latency is 1 cycle: a word pushed at edge N is visible at ValidD/InstrD after edge N. Exception: see FETCHQ_BYPASS_EN.
- StallF and ValidD are decoded combinationally from the registered count, so there is no combinational path from ValidF or StallD to them.
- Head outputs are a combinational read of the entry at head.
- Steady-state throughput is 1 instruction per cycle with StallD = 0. Occupancy stays at 1 in that case.
- StallD held: the head entry and its outputs stay stable.
- Flush during full + stalled: StallF drops in the next cycle.

## Configuration
- FETCHQ_BYPASS_EN defined:
  - When count == 0 and ValidF & ~FlushD, the outputs are driven directly from RDF/PCF/PCPlus4F in the same cycle, with ValidD = 1.
  - If StallD = 0, the word is consumed and not written (count stays 0).
  - If StallD = 1, it is pushed normally.
  - Latency 0 through an empty queue. Creates a combinational path ValidF → ValidD.
- Not defined: there is no bypass; latency is always 1 cycle, as described above.

## Test plan
- Reset: hold rst 2 cycles with ValidF = 1, RDF = 32'hDEADBEEF → after release, ValidD = 0, CountQ = 0, StallF = 0, InstrD = 0.
- Streaming: push PCF = 0x1000, 0x1004, 0x1008 on consecutive cycles with StallD = 0 → PCD shows 0x1000, 0x1004, 0x1008 one cycle later each; PCPlus4D = PCD + 4; CountQ ≤ 1.
- Fill with DEPTH = 4:
  - Stimulus: StallD = 1, push 5 words at 0x2000..0x2010.
  - StallF = 1 after the 4th push and the 5th word is not stored.
  - Release StallD: pops give 0x2000..0x200C in order, then 0x2010 on re-presentation.
- Wrap-around: alternate 3 pushes / 3 pops for 4 rounds → order is preserved across pointer wrap; CountQ returns to 0.
- Flush: with 3 entries queued, assert FlushD with ValidF = 1, PCF = 0x3000 → next cycle CountQ = 0, ValidD = 0; 0x3000 is never output; the next push (0x3004) appears 1 cycle later.
- Simultaneous push/pop at full (CountQ = 4, StallD = 0, ValidF = 1) → head pops, push refused, CountQ = 3.
